// File: rtl/cen_accumulator.sv
// Four-channel block accumulator feeding the centering divider.
// Sums N_SAMPLES accepted sample sets, then pulses sum_valid for one cycle.
module cen_accumulator #(
  parameter int DATA_W    = 32,
  parameter int SUM_W     = 40,
  parameter int N_SAMPLES = 128
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic                             in_valid,
  input  logic [DATA_W-1:0]                x1,
  input  logic [DATA_W-1:0]                x2,
  input  logic [DATA_W-1:0]                x3,
  input  logic [DATA_W-1:0]                x4,
  output logic                             in_ready,
  output logic                             busy,
  output logic [SUM_W-1:0]                 sum1,
  output logic [SUM_W-1:0]                 sum2,
  output logic [SUM_W-1:0]                 sum3,
  output logic [SUM_W-1:0]                 sum4,
  output logic                             sum_valid,
  output logic [$clog2(N_SAMPLES+1)-1:0]   count
);

  localparam int CNT_W = $clog2(N_SAMPLES + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [SUM_W-1:0] r_sum [4];
  logic [CNT_W-1:0] r_count;
  logic             w_clear;
  logic             w_accept;
  logic             w_last;

  // Start is honoured only between blocks; DONE can chain straight into ACC.
  assign w_clear  = start && ((r_state == IDLE) || (r_state == DONE));
  assign w_accept = in_valid && (r_state == ACC);
  assign w_last   = (r_count == CNT_W'(N_SAMPLES - 1));

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = ACC;
      ACC:     if (w_accept && w_last) w_next = DONE;
      DONE:    w_next = start ? ACC : IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_count <= '0;
      for (int i = 0; i < 4; i++) r_sum[i] <= '0;
    end else begin
      r_state <= w_next;
      if (w_clear) begin
        r_count <= '0;
        for (int i = 0; i < 4; i++) r_sum[i] <= '0;
      end else if (w_accept) begin
        r_count  <= r_count + CNT_W'(1);
        r_sum[0] <= r_sum[0] + SUM_W'(x1);
        r_sum[1] <= r_sum[1] + SUM_W'(x2);
        r_sum[2] <= r_sum[2] + SUM_W'(x3);
        r_sum[3] <= r_sum[3] + SUM_W'(x4);
      end
    end
  end

  assign in_ready  = (r_state == ACC);
  assign busy      = (r_state == ACC);
  assign sum_valid = (r_state == DONE);
  assign count     = r_count;
  assign sum1      = r_sum[0];
  assign sum2      = r_sum[1];
  assign sum3      = r_sum[2];
  assign sum4      = r_sum[3];

endmodule

// File: doc/cen_accumulator.md
# cen_accumulator

Four-channel sample accumulator that sits directly upstream of the centering divider in the FastICA preprocessing path. After a start pulse it sums a fixed block of N_SAMPLES unsigned samples per channel. It then presents the four totals on stable, registered outputs and pulses `sum_valid` for one cycle; that pulse drives the divider's enable. The divider's fixed shift of 7 bits means the default block length is 128.

## Interface
- `DATA_W`, 32: width of each unsigned input sample.
- `SUM_W`, 40: width of each accumulated sum; must be ≥ DATA_W + clog2(N_SAMPLES) for overflow-free operation.
- `N_SAMPLES`, 128: samples per channel per block; ≥ 1.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a new block; sampled only in IDLE or DONE.
- `in_valid`  in  1  x1..x4 carry a valid sample set this cycle.
- `x1`, `x2`, `x3`, `x4`  in  DATA_W each  unsigned samples, channels 1–4.
- `in_ready`  out  1  high while in ACC; a sample set is accepted on a cycle with in_valid && in_ready.
- `busy`  out  1  high in ACC.
- `sum1`, `sum2`, `sum3`, `sum4`  out  SUM_W each  registered channel totals.
- `sum_valid`  out  1  one-cycle pulse: sum1..sum4 hold a completed block.
- `count`  out  clog2(N_SAMPLES+1)  samples accepted in the current block.

## Operation
- States: IDLE, ACC, DONE.
- Reset: state IDLE; sum1..4 = 0; count = 0; sum_valid = 0; in_ready = 0; busy = 0.
- IDLE:
  - in_ready = 0, so in_valid is ignored.
  - start = 1 → clear sum1..4 and count to 0, go to ACC.
- ACC:
  - in_ready = 1, busy = 1.
  - On each accepted set: sumN ← sumN + zero-extended xN for all four channels simultaneously; count ← count + 1.
  - start is ignored; there is no restart mid-block.
  - Gaps in in_valid are allowed; sums and count hold.
  - When the accepted set is the N_SAMPLES-th (count == N_SAMPLES−1 before the edge) → go to DONE.
- DONE:
  - Lasts exactly one cycle; sum_valid = 1, in_ready = 0.
  - Next state is IDLE, or ACC if start = 1 that cycle (sums and count cleared at that edge).
- Outputs after DONE: sum1..4 and count hold their final values until the next accepted start or rst.
- Arithmetic:
  - Unsigned; additions are modulo 2^SUM_W.
  - With the default parameters the maximum total is 128·(2^32−1) < 2^39, so there is no wrap.
- Reset mid-block: rst wins over every other input; the partial block is discarded and all outputs return to reset values on that edge.

## Timing
- Sample accept: the sum reflects the sample at the rising edge where in_valid && in_ready; the sample is visible on sumN the next cycle.
- Final sample is accepted at edge k:
  - at edge k, sum1..4 take their final values and state goes to DONE;
  - sum_valid is high during cycle k..k+1.
  - The divider, enabled by sum_valid, latches the sums at edge k+1.
- Minimum block duration, with in_valid held high: 1 start cycle + N_SAMPLES accept cycles + 1 DONE cycle.
- Back-to-back blocks: start asserted during DONE reaches ACC with zero idle cycles. in_ready is 0 in that DONE cycle, so no sample is lost.
- start and in_valid in the same IDLE cycle: only start takes effect; that sample is not accepted.
- All outputs are registered or decoded directly from the state register; no combinational input→output paths except none (in_ready depends on state only).

## Test plan
- Reset values:
  - Assert rst for 2 cycles with random inputs → all sums 0, count 0, sum_valid/in_ready/busy 0.
- Constant block:
  - Stimulus: start, then 128 consecutive sets x1=1, x2=2, x3=1000, x4=0xFFFFFFFF.
  - Required: sum_valid pulses exactly once, one cycle after the 128th accept.
  - Sums = 128, 256, 128000, 0x7F_FFFF_FF80; count = 128.
- Ramp with gaps:
  - Stimulus: xN = i for i = 0..127, with in_valid deasserted every third cycle.
  - Required: sums = 8128 on all channels; no extra samples accepted; sum_valid still a single pulse.
- Back-to-back:
  - Stimulus: start held in the DONE cycle, second block all 5s.
  - Required: no idle cycle; first sums are visible during DONE; second block gives sums = 640.
- Ignored controls:
  - start pulsed at sample 50 → block still completes at 128 accepts with unchanged sums.
  - in_valid in IDLE → count stays 0.
- Reset mid-block:
  - rst at sample 70 → next cycle everything is 0 and state is IDLE.
  - A following full block sums correctly, with no residue from the aborted block.
